// File: rtl/spi_rom_reader_if.sv
// spi_rom_reader_if: request side and SPI_Master handshake bundle of spi_rom_reader
interface spi_rom_reader_if #(
    parameter int LEN_W = 8
);
    logic             rd_start_i;
    logic [23:0]      addr_i;
    logic [LEN_W-1:0] len_i;
    logic [7:0]       data_o;
    logic             data_valid_o;
    logic             busy_o;
    logic             done_o;
    logic             spi_ena_o;
    logic             spi_start_o;
    logic [7:0]       spi_tx_o;
    logic [7:0]       spi_rx_i;
    logic             spi_busy_i;
    logic             spi_irq_i;
    logic             spi_ack_o;
    logic             ss_n_o;

    modport slave (
        input  rd_start_i, addr_i, len_i, spi_rx_i, spi_busy_i, spi_irq_i,
        output data_o, data_valid_o, busy_o, done_o, spi_ena_o, spi_start_o,
               spi_tx_o, spi_ack_o, ss_n_o
    );

    modport master (
        output rd_start_i, addr_i, len_i, spi_rx_i, spi_busy_i, spi_irq_i,
        input  data_o, data_valid_o, busy_o, done_o, spi_ena_o, spi_start_o,
               spi_tx_o, spi_ack_o, ss_n_o
    );
endinterface

// File: rtl/spi_rom_reader.sv
// spi_rom_reader: serial NOR flash read sequencer driving an SPI_Master byte engine
// Optional feature macro SPI_ROM_FAST_READ_EN: FAST READ (0x0B) with one dummy byte before data
module spi_rom_reader #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 8
) (
    input logic             clk_i,
    input logic             rst_n_i,
    spi_rom_reader_if.slave bus
);
`ifdef SPI_ROM_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE, SS_SETUP, CMD, ADDR2, ADDR1, ADDR0,
`ifdef SPI_ROM_FAST_READ_EN
        DUMMY,
`endif
        DATA, SS_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_wait;
    logic             w_wait_nx;
    logic [CW-1:0]    r_cnt;
    logic [LEN_W-1:0] r_bytes;
    logic [23:0]      r_addr;
    logic [7:0]       r_data;
    logic             r_dv;
    logic             r_done;
    logic             r_busy;
    logic             r_ss_n;
    logic             w_ena;
    logic             w_slot;
    logic             w_start;
    logic             w_ack;
    logic             w_last;
    logic [7:0]       w_tx;

    assign w_ena  = r_cnt == CW'(CLK_DIV - 1);
    assign w_last = r_bytes == LEN_W'(1);

    // Half-SCK enable divider, realigned on every byte start so the first edge is CLK_DIV cycles later
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_cnt <= '0;
        else          r_cnt <= (w_start || w_ena) ? '0 : r_cnt + CW'(1);
    end

    // State register; r_wait separates the issue phase from the wait-for-irq phase of a byte slot
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_wait  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_wait  <= w_wait_nx;
        end
    end

    // Next state, byte-slot handshake and transmit byte selection
    always_comb begin
        w_state_nx = r_state;
        w_wait_nx  = r_wait;
        w_slot     = 1'b0;
        w_tx       = 8'h00;
        case (r_state)
            IDLE:     w_state_nx = bus.rd_start_i ? SS_SETUP : IDLE;
            SS_SETUP: w_state_nx = w_ena ? CMD : SS_SETUP;
            CMD:      begin w_slot = 1'b1; w_tx = CMD_BYTE;       end
            ADDR2:    begin w_slot = 1'b1; w_tx = r_addr[23:16];  end
            ADDR1:    begin w_slot = 1'b1; w_tx = r_addr[15:8];   end
            ADDR0:    begin w_slot = 1'b1; w_tx = r_addr[7:0];    end
`ifdef SPI_ROM_FAST_READ_EN
            DUMMY:    w_slot = 1'b1;
`endif
            DATA:     w_slot = 1'b1;
            SS_HOLD:  w_state_nx = w_ena ? IDLE : SS_HOLD;
            default:  w_state_nx = IDLE;
        endcase
        w_start = w_slot && !r_wait && !bus.spi_busy_i && !bus.spi_irq_i;
        w_ack   = w_slot && r_wait && bus.spi_irq_i;
        if (w_start) w_wait_nx = 1'b1;
        if (w_ack) begin
            w_wait_nx = 1'b0;
            case (r_state)
                CMD:     w_state_nx = ADDR2;
                ADDR2:   w_state_nx = ADDR1;
                ADDR1:   w_state_nx = ADDR0;
`ifdef SPI_ROM_FAST_READ_EN
                ADDR0:   w_state_nx = DUMMY;
                DUMMY:   w_state_nx = DATA;
`else
                ADDR0:   w_state_nx = DATA;
`endif
                default: w_state_nx = w_last ? SS_HOLD : DATA;
            endcase
        end
    end

    // Request capture, received-data register, byte counter and chip-select/busy/done flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr  <= '0;
            r_bytes <= '0;
            r_data  <= '0;
            r_dv    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ss_n  <= 1'b1;
        end else begin
            r_dv   <= 1'b0;
            r_done <= 1'b0;
            if (r_state == IDLE && bus.rd_start_i) begin
                r_addr  <= bus.addr_i;
                r_bytes <= bus.len_i;
                r_busy  <= 1'b1;
                r_ss_n  <= 1'b0;
            end
            if (r_state == DATA && w_ack) begin
                r_data  <= bus.spi_rx_i;
                r_dv    <= 1'b1;
                r_bytes <= r_bytes - LEN_W'(1);
            end
            if (r_state == SS_HOLD && w_ena) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
                r_ss_n <= 1'b1;
            end
        end
    end

    assign bus.spi_ena_o    = w_ena;
    assign bus.spi_start_o  = w_start;
    assign bus.spi_ack_o    = w_ack;
    assign bus.spi_tx_o     = w_tx;
    assign bus.data_o       = r_data;
    assign bus.data_valid_o = r_dv;
    assign bus.busy_o       = r_busy;
    assign bus.done_o       = r_done;
    assign bus.ss_n_o       = r_ss_n;
endmodule

// File: tb/tb_spi_rom_reader.sv
// tb_spi_rom_reader: directed bench for spi_rom_reader at CLK_DIV 4, 2 and 6 with an SPI_Master and flash model
module tb_spi_rom_reader;
`ifdef SPI_ROM_FAST_READ_EN
    localparam int         HDR = 5;
    localparam logic [7:0] CMD = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] CMD = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b1;
    logic        rd_start = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0]  len = '0;
    logic [7:0]  flash [256];
    int          checks = 0;
    int          fails = 0;
    int          nb_a [3];
    int          dv_a [3];
    int          done_a [3];
    int          ss_bad_a [3];
    int          ack_bad_a [3];
    int          acks_a [3];
    int          lat_bad_a [3];
    int          lats_a [3];
    int          cyc_a [3];
    logic        busy_a [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int DIV = (k == 0) ? 4 : (k == 1) ? 2 : 6;
        spi_rom_reader_if #(.LEN_W(8)) bus ();
        spi_rom_reader #(.CLK_DIV(DIV), .LEN_W(8)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
        logic       m_busy;
        logic       m_irq;
        logic [7:0] m_rx;
        logic [3:0] m_ec;
        int         m_slot;
        int         nb, dv, done, ss_bad, ack_bad, acks, ack_run, lat_bad, lats, lat, cyc;
        logic       run;
        logic [7:0] mosi [8];
        logic [7:0] rxlog [300];
        assign bus.rd_start_i = rd_start;
        assign bus.addr_i     = addr;
        assign bus.len_i      = len;
        assign bus.spi_busy_i = m_busy;
        assign bus.spi_irq_i  = m_irq;
        assign bus.spi_rx_i   = m_rx;
        assign nb_a[k]        = nb;
        assign dv_a[k]        = dv;
        assign done_a[k]      = done;
        assign ss_bad_a[k]    = ss_bad;
        assign ack_bad_a[k]   = ack_bad;
        assign acks_a[k]      = acks;
        assign lat_bad_a[k]   = lat_bad;
        assign lats_a[k]      = lats;
        assign cyc_a[k]       = cyc;
        assign busy_a[k]      = bus.busy_o;

        // SPI_Master byte engine: 16 enable pulses per byte, irq held until acknowledged
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_busy <= 1'b0;
                m_irq  <= 1'b0;
                m_rx   <= 8'h00;
                m_ec   <= 4'd0;
                m_slot <= 0;
            end else begin
                if (bus.spi_ack_o) m_irq <= 1'b0;
                if (bus.ss_n_o) m_slot <= 0;
                if (!m_busy && bus.spi_start_o) begin
                    m_busy <= 1'b1;
                    m_ec   <= 4'd0;
                end else if (m_busy && bus.spi_ena_o) begin
                    m_ec <= m_ec + 4'd1;
                    if (m_ec == 4'd15) begin
                        m_busy <= 1'b0;
                        m_irq  <= 1'b1;
                        m_rx   <= (m_slot < HDR) ? 8'hEE : flash[8'(m_slot - HDR)];
                        m_slot <= m_slot + 1;
                    end
                end
            end
        end

        // Monitor: MOSI log, received data log, ss/busy consistency, ack width, start-to-enable latency
        always @(negedge clk) begin
            if (clr) begin
                nb = 0; dv = 0; done = 0; ss_bad = 0; ack_bad = 0; acks = 0; ack_run = 0;
                lat_bad = 0; lats = 0; lat = 0; cyc = 0; run = 1'b0;
            end else begin
                if (bus.spi_start_o) begin
                    if (nb < 8) mosi[nb] = bus.spi_tx_o;
                    nb++;
                end
                if (bus.data_valid_o) begin
                    if (dv < 300) rxlog[dv] = bus.data_o;
                    dv++;
                end
                if (bus.done_o) done++;
                if (bus.busy_o === bus.ss_n_o) ss_bad++;
                if (bus.busy_o) cyc++;
                if (bus.spi_ack_o) ack_run++;
                else begin
                    if (ack_run != 0) begin
                        if (ack_run != 1) ack_bad++;
                        acks++;
                    end
                    ack_run = 0;
                end
                if (bus.spi_start_o) begin
                    run = 1'b1;
                    lat = 0;
                end else if (run) begin
                    lat++;
                    if (bus.spi_ena_o) begin
                        run = 1'b0;
                        lats++;
                        if (lat != DIV) lat_bad++;
                    end
                end
            end
        end
    end

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 6;
    endfunction

    function automatic logic [7:0] hdr_byte(input int i, input logic [23:0] a);
        return (i == 0) ? CMD : (i == 1) ? a[23:16] : (i == 2) ? a[15:8] : (i == 3) ? a[7:0] : 8'h00;
    endfunction

    task automatic pulse_start(input logic [23:0] a, input logic [7:0] n);
        @(posedge clk);
        #1 rd_start = 1'b1;
        addr = a;
        len = n;
        @(posedge clk);
        #1 rd_start = 1'b0;
    endtask

    task automatic clear_mon;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while (!(done_a[0] > 0 && done_a[1] > 0 && done_a[2] > 0 && !busy_a[0] && !busy_a[1] && !busy_a[2]) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin fails++; $display("FAIL %s_timeout: no done after %0d cycles", tag, n); end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (g[0].bus.ss_n_o !== 1'b1) begin fails++; $display("FAIL rst_ss_n: got %b want 1", g[0].bus.ss_n_o); end
        checks++; if (g[0].bus.busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", g[0].bus.busy_o); end
        checks++; if (g[0].bus.data_o !== 8'h00) begin fails++; $display("FAIL rst_data: got %h want 00", g[0].bus.data_o); end
        checks++; if (g[0].bus.data_valid_o !== 1'b0) begin fails++; $display("FAIL rst_dv: got %b want 0", g[0].bus.data_valid_o); end
        checks++; if (g[0].bus.done_o !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", g[0].bus.done_o); end
        checks++; if (g[0].bus.spi_start_o !== 1'b0) begin fails++; $display("FAIL rst_start: got %b want 0", g[0].bus.spi_start_o); end
        checks++; if (g[0].bus.spi_ack_o !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b want 0", g[0].bus.spi_ack_o); end
        checks++; if (g[0].bus.spi_tx_o !== 8'h00) begin fails++; $display("FAIL rst_tx: got %h want 00", g[0].bus.spi_tx_o); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (nb_a[0] !== 0) begin fails++; $display("FAIL idle_no_start: got %0d bytes want 0", nb_a[0]); end
        checks++; if (g[0].bus.ss_n_o !== 1'b1) begin fails++; $display("FAIL idle_ss_n: got %b want 1", g[0].bus.ss_n_o); end
    endtask

    task automatic test_basic_read;
        clear_mon;
        pulse_start(24'h123456, 8'd2);
        wait_idle(5000, "basic");
        checks++; if (nb_a[0] !== HDR + 2) begin fails++; $display("FAIL basic_nbytes: got %0d want %0d", nb_a[0], HDR + 2); end
        for (int i = 0; i < HDR + 2; i++) begin
            checks++;
            if (g[0].mosi[i] !== hdr_byte(i, 24'h123456)) begin
                fails++; $display("FAIL basic_mosi[%0d]: got %h want %h", i, g[0].mosi[i], hdr_byte(i, 24'h123456));
            end
        end
        checks++; if (dv_a[0] !== 2) begin fails++; $display("FAIL basic_dv_count: got %0d want 2", dv_a[0]); end
        checks++; if (g[0].rxlog[0] !== 8'hA5) begin fails++; $display("FAIL basic_rx0: got %h want a5", g[0].rxlog[0]); end
        checks++; if (g[0].rxlog[1] !== 8'h3C) begin fails++; $display("FAIL basic_rx1: got %h want 3c", g[0].rxlog[1]); end
        checks++; if (g[0].bus.data_o !== 8'h3C) begin fails++; $display("FAIL basic_data_hold: got %h want 3c", g[0].bus.data_o); end
        checks++; if (done_a[0] !== 1) begin fails++; $display("FAIL basic_done_count: got %0d want 1", done_a[0]); end
        checks++; if (ss_bad_a[0] !== 0) begin fails++; $display("FAIL basic_ss_vs_busy: got %0d bad cycles want 0", ss_bad_a[0]); end
    endtask

    task automatic test_timing;
        int nbytes = HDR + 3;
        clear_mon;
        pulse_start(24'hABCDEF, 8'd3);
        wait_idle(8000, "timing");
        for (int k = 0; k < 3; k++) begin
            int lo = nbytes * 16 * div_of(k);
            int hi = nbytes * (16 * div_of(k) + 2) + 2 * div_of(k) + 4;
            checks++; if (nb_a[k] !== nbytes) begin fails++; $display("FAIL tim%0d_nbytes: got %0d want %0d", k, nb_a[k], nbytes); end
            checks++; if (lats_a[k] !== nbytes) begin fails++; $display("FAIL tim%0d_lat_count: got %0d want %0d", k, lats_a[k], nbytes); end
            checks++; if (lat_bad_a[k] !== 0) begin fails++; $display("FAIL tim%0d_ena_latency: got %0d wrong want 0", k, lat_bad_a[k]); end
            checks++; if (acks_a[k] !== nbytes) begin fails++; $display("FAIL tim%0d_ack_count: got %0d want %0d", k, acks_a[k], nbytes); end
            checks++; if (ack_bad_a[k] !== 0) begin fails++; $display("FAIL tim%0d_ack_width: got %0d wide acks want 0", k, ack_bad_a[k]); end
            checks++; if (cyc_a[k] < lo || cyc_a[k] > hi) begin fails++; $display("FAIL tim%0d_length: got %0d want %0d..%0d", k, cyc_a[k], lo, hi); end
            checks++; if (ss_bad_a[k] !== 0) begin fails++; $display("FAIL tim%0d_ss_vs_busy: got %0d want 0", k, ss_bad_a[k]); end
        end
        checks++; if (!(cyc_a[1] < cyc_a[0] && cyc_a[0] < cyc_a[2])) begin
            fails++; $display("FAIL tim_scaling: got div2=%0d div4=%0d div6=%0d want increasing", cyc_a[1], cyc_a[0], cyc_a[2]);
        end
    endtask

    task automatic test_len_zero;
        clear_mon;
        pulse_start(24'h000100, 8'd0);
        wait_idle(40000, "len0");
        checks++; if (dv_a[0] !== 256) begin fails++; $display("FAIL len0_dv_count: got %0d want 256", dv_a[0]); end
        checks++; if (nb_a[0] !== HDR + 256) begin fails++; $display("FAIL len0_nbytes: got %0d want %0d", nb_a[0], HDR + 256); end
        checks++; if (done_a[0] !== 1) begin fails++; $display("FAIL len0_done_count: got %0d want 1", done_a[0]); end
        checks++; if (g[0].rxlog[2] !== 8'h58) begin fails++; $display("FAIL len0_rx2: got %h want 58", g[0].rxlog[2]); end
        checks++; if (g[0].rxlog[128] !== 8'hDA) begin fails++; $display("FAIL len0_rx128: got %h want da", g[0].rxlog[128]); end
        checks++; if (g[0].rxlog[255] !== 8'hA5) begin fails++; $display("FAIL len0_rx255: got %h want a5", g[0].rxlog[255]); end
        checks++; if (dv_a[2] !== 256) begin fails++; $display("FAIL len0_div6_dv_count: got %0d want 256", dv_a[2]); end
    endtask

    task automatic test_ignore_restart;
        clear_mon;
        pulse_start(24'h123456, 8'd2);
        repeat (60) @(posedge clk);
        pulse_start(24'h000000, 8'd5);
        wait_idle(5000, "restart");
        repeat (300) @(negedge clk);
        checks++; if (busy_a[0] !== 1'b0) begin fails++; $display("FAIL restart_busy: got %b want 0", busy_a[0]); end
        checks++; if (nb_a[0] !== HDR + 2) begin fails++; $display("FAIL restart_nbytes: got %0d want %0d", nb_a[0], HDR + 2); end
        checks++; if (g[0].mosi[1] !== 8'h12) begin fails++; $display("FAIL restart_addr2: got %h want 12", g[0].mosi[1]); end
        checks++; if (g[0].mosi[3] !== 8'h56) begin fails++; $display("FAIL restart_addr0: got %h want 56", g[0].mosi[3]); end
        checks++; if (dv_a[0] !== 2) begin fails++; $display("FAIL restart_dv_count: got %0d want 2", dv_a[0]); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (done_a[k] !== 1) begin fails++; $display("FAIL restart%0d_done_count: got %0d want 1", k, done_a[k]); end
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        clear_mon;
        pulse_start(24'h123456, 8'd2);
        while (!(g[0].bus.spi_start_o && g[0].bus.spi_tx_o == 8'h34) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 3000) begin fails++; $display("FAIL midrst_reach_addr1: got timeout after %0d cycles want ADDR1 start", n); end
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (g[0].bus.ss_n_o !== 1'b1) begin fails++; $display("FAIL midrst_ss_n_async: got %b want 1", g[0].bus.ss_n_o); end
        checks++; if (g[0].bus.busy_o !== 1'b0) begin fails++; $display("FAIL midrst_busy_async: got %b want 0", g[0].bus.busy_o); end
        repeat (2) @(negedge clk);
        checks++; if (done_a[0] !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d want 0", done_a[0]); end
        checks++; if (dv_a[0] !== 0) begin fails++; $display("FAIL midrst_no_data: got %0d want 0", dv_a[0]); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon;
        pulse_start(24'h000010, 8'd1);
        wait_idle(5000, "post_reset");
        checks++; if (nb_a[0] !== HDR + 1) begin fails++; $display("FAIL post_nbytes: got %0d want %0d", nb_a[0], HDR + 1); end
        for (int i = 0; i < HDR + 1; i++) begin
            checks++;
            if (g[0].mosi[i] !== hdr_byte(i, 24'h000010)) begin
                fails++; $display("FAIL post_mosi[%0d]: got %h want %h", i, g[0].mosi[i], hdr_byte(i, 24'h000010));
            end
        end
        checks++; if (dv_a[0] !== 1) begin fails++; $display("FAIL post_dv_count: got %0d want 1", dv_a[0]); end
        checks++; if (g[0].rxlog[0] !== 8'hA5) begin fails++; $display("FAIL post_rx0: got %h want a5", g[0].rxlog[0]); end
        checks++; if (done_a[0] !== 1) begin fails++; $display("FAIL post_done_count: got %0d want 1", done_a[0]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) flash[i] = 8'(i) ^ 8'h5A;
        flash[0] = 8'hA5;
        flash[1] = 8'h3C;
        test_reset;
        test_basic_read;
        test_timing;
        test_len_zero;
        test_ignore_restart;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
